noc_input_buffer_hs: RTL and testbench

- Router input-port receiver. It is the downstream end of the RTS/DCTS link driven by each output-port arbiter of the upstream router.
- Accepts flits from the upstream link using a two-phase RTS/CTS handshake and stores them in a small circular FIFO.
- Presents the head flit to the local crossbar and routing logic.
- Pops the head flit when any local output arbiter grants this input.

---
 rtl/noc_input_buffer_hs_if.sv | 42 ++++
 rtl/noc_input_buffer_hs.sv | 97 +++++++++
 tb/tb_noc_input_buffer_hs.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/noc_input_buffer_hs_if.sv
// Router input-port bundle: the upstream RTS/CTS link plus the local
// crossbar-side pop requests and head-flit/status view of the FIFO.
interface noc_input_buffer_hs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);

  localparam int PTR_W = $clog2(DEPTH);

  // Upstream link
  logic [DATA_WIDTH-1:0] RX;
  logic                  DRTS;
  logic                  CTS;

  // Local output-arbiter grants
  logic                  read_en_N;
  logic                  read_en_E;
  logic                  read_en_W;
  logic                  read_en_S;
  logic                  read_en_L;

  // Head flit and occupancy status
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  empty;
  logic                  full;
  logic [PTR_W:0]        count;

  // Environment side: upstream router and local arbiters
  modport master (
    output RX, DRTS,
    output read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    input  CTS, Data_out, empty, full, count
  );

  // Buffer side
  modport slave (
    input  RX, DRTS,
    input  read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    output CTS, Data_out, empty, full, count
  );

endinterface

// File: rtl/noc_input_buffer_hs.sv
// Router input-port receiver. Accepts flits from the upstream link with a
// two-phase RTS/CTS handshake, stores them in a small circular FIFO and
// shows the head flit to the crossbar. Any local output grant pops it.
module noc_input_buffer_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  noc_input_buffer_hs_if.slave    bus
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_next;
  logic             cts_q;
  logic             cts_next;

  logic             write_en;
  logic             read_en;
  logic             pop;
  logic             empty_int;
  logic             full_int;

  // Status is derived purely from the registered occupancy.
  assign empty_int = (count_q == '0);
  assign full_int  = (count_q == CNT_FULL);

  // A flit is captured on the edge where the upstream still holds RTS and
  // our CTS pulse is high; several simultaneous grants are a single pop.
  assign write_en = bus.DRTS & cts_q;
  assign read_en  = bus.read_en_N | bus.read_en_E | bus.read_en_W |
                    bus.read_en_S | bus.read_en_L;
  assign pop      = read_en & ~empty_int;

  // CTS is a one-cycle pulse: raised only when RTS is seen, CTS is low and
  // there is room, so a second write can never land before re-evaluation.
  always_comb begin
    cts_next = 1'b0;
    if (bus.DRTS && !cts_q && !full_int) begin
      cts_next = 1'b1;
    end
  end

  // Occupancy bookkeeping; simultaneous write and pop cancel out.
  always_comb begin
    count_next = count_q;
    case ({write_en, pop})
      2'b10:   count_next = count_q + CNT_ONE;
      2'b01:   count_next = count_q - CNT_ONE;
      default: count_next = count_q;
    endcase
  end

  // Handshake, pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cts_q   <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      cts_q   <= cts_next;
      count_q <= count_next;
      if (write_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Flit storage; contents are left alone by reset and only the valid
  // window between the pointers is ever meaningful.
  always_ff @(posedge clk) begin
    if (write_en && !rst) begin
      mem[wr_ptr] <= bus.RX;
    end
  end

  assign bus.CTS      = cts_q;
  assign bus.Data_out = mem[rd_ptr];
  assign bus.empty    = empty_int;
  assign bus.full     = full_int;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_noc_input_buffer_hs.sv
// Directed bench for the router input buffer: handshake timing, fill to
// full, pop with wrap-around refill, merged grants, empty reads, write and
// pop on the same edge, and reset in the middle of a handshake.
module tb_noc_input_buffer_hs;

  logic clk;
  logic rst;
  int   test_count;
  int   fail_count;

  noc_input_buffer_hs_if #(.DATA_WIDTH(32), .DEPTH(4)) bus ();

  noc_input_buffer_hs #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Single handshake: present the flit, wait (bounded) for CTS, let the
  // write edge pass, then drop RTS as the upstream would.
  task automatic applyStimulus(input logic [31:0] flit, input string tag);
    int n;
    n = 0;
    bus.RX   = flit;
    bus.DRTS = 1'b1;
    while (bus.CTS !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_cts_seen"}, 32'(bus.CTS), 32'd1);
    @(negedge clk);
    bus.DRTS = 1'b0;
  endtask

  task automatic clearReads();
    bus.read_en_N = 1'b0;
    bus.read_en_E = 1'b0;
    bus.read_en_W = 1'b0;
    bus.read_en_S = 1'b0;
    bus.read_en_L = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed sequence; inputs change and outputs are sampled on negedges.
  initial begin
    test_count = 0;
    fail_count = 0;
    rst      = 1'b1;
    bus.RX   = '0;
    bus.DRTS = 1'b0;
    clearReads();
    @(negedge clk);
    doReset();

    checkOutput("reset_cts",   32'(bus.CTS),   32'd0);
    checkOutput("reset_count", 32'(bus.count), 32'd0);
    checkOutput("reset_empty", 32'(bus.empty), 32'd1);
    checkOutput("reset_full",  32'(bus.full),  32'd0);

    // Test 1: single handshake timing
    bus.RX   = 32'hA5A5_0001;
    bus.DRTS = 1'b1;
    @(negedge clk);
    checkOutput("t1_cts_pulse", 32'(bus.CTS), 32'd1);
    checkOutput("t1_no_write_yet", 32'(bus.count), 32'd0);
    @(negedge clk);
    checkOutput("t1_cts_drop", 32'(bus.CTS),      32'd0);
    checkOutput("t1_count",    32'(bus.count),    32'd1);
    checkOutput("t1_empty",    32'(bus.empty),    32'd0);
    checkOutput("t1_data",     bus.Data_out,      32'hA5A5_0001);
    bus.DRTS = 1'b0;

    // Test 2: fill from a clean state with four back-to-back handshakes
    doReset();
    applyStimulus(32'd1, "t2_w1");
    applyStimulus(32'd2, "t2_w2");
    applyStimulus(32'd3, "t2_w3");
    applyStimulus(32'd4, "t2_w4");
    checkOutput("t2_full",  32'(bus.full),  32'd1);
    checkOutput("t2_count", 32'(bus.count), 32'd4);
    bus.RX   = 32'd5;
    bus.DRTS = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t2_cts_blocked", 32'(bus.CTS), 32'd0);
    end
    checkOutput("t2_still_full", 32'(bus.count), 32'd4);

    // Test 3: pop while flit 5 is pending; it refills slot 0
    checkOutput("t3_head_before", bus.Data_out, 32'd1);
    bus.read_en_E = 1'b1;
    @(negedge clk);
    bus.read_en_E = 1'b0;
    checkOutput("t3_head_after", bus.Data_out,   32'd2);
    checkOutput("t3_count",      32'(bus.count), 32'd3);
    checkOutput("t3_not_full",   32'(bus.full),  32'd0);
    checkOutput("t3_cts_low",    32'(bus.CTS),   32'd0);
    @(negedge clk);
    checkOutput("t3_cts_rise",   32'(bus.CTS),   32'd1);
    @(negedge clk);
    bus.DRTS = 1'b0;
    checkOutput("t3_refill_count", 32'(bus.count), 32'd4);
    checkOutput("t3_refill_full",  32'(bus.full),  32'd1);
    checkOutput("t3_refill_cts",   32'(bus.CTS),   32'd0);

    // Test 4: bring count to 2, then merged grants count as one pop
    bus.read_en_W = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.read_en_W = 1'b0;
    checkOutput("t4_count2", 32'(bus.count), 32'd2);
    checkOutput("t4_head4",  bus.Data_out,   32'd4);
    bus.read_en_N = 1'b1;
    bus.read_en_L = 1'b1;
    @(negedge clk);
    clearReads();
    checkOutput("t4_merged_pop", 32'(bus.count), 32'd1);
    checkOutput("t4_wrap_data",  bus.Data_out,   32'd5);
    bus.read_en_S = 1'b1;
    @(negedge clk);
    checkOutput("t4_drain_count", 32'(bus.count), 32'd0);
    checkOutput("t4_drain_empty", 32'(bus.empty), 32'd1);
    @(negedge clk);
    @(negedge clk);
    bus.read_en_S = 1'b0;
    checkOutput("t4_empty_read_count", 32'(bus.count), 32'd0);
    checkOutput("t4_empty_read_empty", 32'(bus.empty), 32'd1);
    applyStimulus(32'h0000_0006, "t4_w6");
    checkOutput("t4_rdptr_held", bus.Data_out,   32'h0000_0006);
    checkOutput("t4_count1",     32'(bus.count), 32'd1);

    // Test 5: write and pop on the same edge
    bus.RX   = 32'hDEAD_BEEF;
    bus.DRTS = 1'b1;
    @(negedge clk);
    checkOutput("t5_cts", 32'(bus.CTS), 32'd1);
    bus.read_en_L = 1'b1;
    @(negedge clk);
    bus.read_en_L = 1'b0;
    bus.DRTS = 1'b0;
    checkOutput("t5_count", 32'(bus.count), 32'd1);
    checkOutput("t5_data",  bus.Data_out,   32'hDEAD_BEEF);

    // RTS withdrawn while CTS is high: no write, CTS still drops
    bus.RX   = 32'h1234_5678;
    bus.DRTS = 1'b1;
    @(negedge clk);
    checkOutput("abort_cts", 32'(bus.CTS), 32'd1);
    bus.DRTS = 1'b0;
    @(negedge clk);
    checkOutput("abort_cts_drop", 32'(bus.CTS),   32'd0);
    checkOutput("abort_count",    32'(bus.count), 32'd1);
    checkOutput("abort_data",     bus.Data_out,   32'hDEAD_BEEF);

    // Test 6: reset lands on the CTS cycle
    bus.RX   = 32'h0000_0077;
    bus.DRTS = 1'b1;
    @(negedge clk);
    checkOutput("t6_cts", 32'(bus.CTS), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    bus.DRTS = 1'b0;
    checkOutput("t6_cts_low", 32'(bus.CTS),   32'd0);
    checkOutput("t6_count",   32'(bus.count), 32'd0);
    checkOutput("t6_empty",   32'(bus.empty), 32'd1);
    checkOutput("t6_full",    32'(bus.full),  32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_no_late_write", 32'(bus.count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
